// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one shared 4-bit ripple-carry adder is stepped over NIBBLES slices, LSB first.
// Optional signed-overflow output is enabled by defining SADD_OVF_EN.

module bit_rca (
    output logic [3:0] sum,
    output logic       c4,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c4 = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
`ifdef SADD_OVF_EN
    output logic                   ovf,
`endif
    output logic                   cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d, cout_q, cout_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            ovf_q, ovf_d;

    logic [3:0]      nib_a, nib_b, nib_s;
    logic            nib_c4;

    bit_rca u_rca (
        .sum (nib_s),
        .c4  (nib_c4),
        .a   (nib_a),
        .b   (nib_b),
        .cin (carry_q)
    );

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        acc_d = acc_q;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == i[IW-1:0]) begin
                nib_a             = a_q[4*i +: 4];
                nib_b             = b_q[4*i +: 4];
                acc_d[4*i +: 4]   = nib_s;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                carry_d = nib_c4;
                if (idx_q == LAST) begin
                    // acc_d already holds the top nibble, so the result is complete this cycle
                    sum_d   = acc_d;
                    cout_d  = nib_c4;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= (state_q == RUN) ? acc_d : acc_q;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SADD_OVF_EN
    assign ovf  = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4); ovf checks compile in with SADD_OVF_EN.

module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic         ovf_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SADD_OVF_EN
        .ovf   (ovf_o),
`endif
        .cout  (cout)
    );
`ifndef SADD_OVF_EN
    assign ovf_o = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, then confirm N busy cycles, done on the N-th edge and the result.
    task automatic run_op(input vec_t v, input string name);
        int lat;
        start = 1'b1; a = v.a; b = v.b; cin = v.cin;
        tick();
        start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin;
        lat = 0;
        while (!done && lat < 20) begin
            check({name, " busy"}, {31'b0, busy}, 32'd1);
            tick();
            lat++;
        end
        check({name, " latency"}, lat, N);
        check({name, " sum"}, {16'b0, sum}, {16'b0, v.s});
        check({name, " cout"}, {31'b0, cout}, {31'b0, v.c});
`ifdef SADD_OVF_EN
        check({name, " ovf"}, {31'b0, ovf_o}, {31'b0, v.v});
`endif
        tick();
        check({name, " done pulse"}, {31'b0, done}, 32'd0);
        check({name, " sum hold"}, {16'b0, sum}, {16'b0, v.s});
    endtask

    vec_t vecs[8];

    initial begin
        int gap;
        int cyc;
        vec_t tmp;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[3] = '{16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0003, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[7] = '{16'hA5C3, 16'h5A3D, 1'b1, 16'h0001, 1'b1, 1'b0};

        // Reset with noisy inputs
        start = 1'b1; a = 16'hBEEF; b = 16'hCAFE; cin = 1'b1;
        #17;
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst sum", {16'b0, sum}, 32'd0);
        check("rst cout", {31'b0, cout}, 32'd0);
        check("rst ovf", {31'b0, ovf_o}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("idle busy", {31'b0, busy}, 32'd0);
        check("idle done", {31'b0, done}, 32'd0);

        for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back with start held high
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; cin = 1'b1;
        tick();
        a = 16'h1234; b = 16'h4321; cin = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin tick(); cyc++; end
        check("b2b first sum", {16'b0, sum}, 32'h0000);
        check("b2b first cout", {31'b0, cout}, 32'd1);
        gap = 0;
        tick(); gap++;
        check("b2b busy after accept", {31'b0, busy}, 32'd1);
        while (!done && gap < 20) begin tick(); gap++; end
        start = 1'b0;
        check("b2b spacing", gap, N + 1);
        check("b2b second sum", {16'b0, sum}, 32'h5555);
        check("b2b second cout", {31'b0, cout}, 32'd0);
        tick();
        check("b2b single pulse", {31'b0, done}, 32'd0);
        tick(); tick(); tick();

        // Start and operand changes during RUN are ignored
        start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 16'hFFFF; b = 16'h1234; cin = 1'b1;
        tick();
        start = 1'b0;
        cyc = 2;
        while (!done && cyc < 20) begin tick(); cyc++; end
        check("ign latency", cyc, N);
        check("ign sum", {16'b0, sum}, 32'h0002);
        cyc = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (done) cyc++; end
        check("ign no extra done", cyc, 0);

        // Reset mid-RUN discards the operation
        start = 1'b1; a = 16'h0505; b = 16'h0505; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst sum", {16'b0, sum}, 32'd0);
        tick();
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (done || busy) cyc++; end
        check("midrst quiet", cyc, 0);
        tmp = '{16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0};
        run_op(tmp, "post rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
